// File: rtl/shift_right_seq_pkg.sv
// Shared definitions for the sequential right shifter.
//   - op_e      : shift type encoding (LSR / ASR / ROR, 2'b11 reserved -> LSR)
//   - state_e   : control FSM state encoding
//   - DEFAULT_WIDTH : default operand width
//   - eff_amount: maps the requested 6-bit shift count to the number of
//                 single-bit steps actually executed.
package shift_right_seq_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_LSR = 2'b00,
        OP_ASR = 2'b01,
        OP_ROR = 2'b10,
        OP_RSV = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    // Linear shifts saturate at 32 steps (everything shifted out); rotates
    // are periodic, so only the low five bits matter.
    function automatic logic [5:0] eff_amount(input op_e op, input logic [5:0] amount);
        if (op == OP_ROR) begin
            return {1'b0, amount[4:0]};
        end else if (amount > 6'd32) begin
            return 6'd32;
        end else begin
            return amount;
        end
    endfunction

endpackage

// File: rtl/shr_step.sv
// One-position right step, purely combinational.
//   data_i : operand before the step
//   op_i   : shift type (LSR fills 0, ASR copies MSB, ROR wraps bit 0)
//   data_o : operand after the step
//   bit_o  : bit shifted out of position 0
module shr_step
    import shift_right_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] data_i,
    input  op_e              op_i,
    output logic [WIDTH-1:0] data_o,
    output logic             bit_o
);

    always_comb begin
        bit_o  = data_i[0];
        data_o = {1'b0, data_i[WIDTH-1:1]};
        case (op_i)
            OP_ASR:  data_o = {data_i[WIDTH-1], data_i[WIDTH-1:1]};
            OP_ROR:  data_o = {data_i[0], data_i[WIDTH-1:1]};
            default: ;  // LSR and the reserved code both zero-fill
        endcase
    end

endmodule

// File: rtl/shift_right_seq.sv
// Sequential right shifter: one bit position per clock.
//   clk    : clock, rising edge
//   reset  : synchronous active-high reset
//   start  : request, accepted only in IDLE
//   in     : operand, captured on the accepting edge
//   amount : shift count 0..63, captured on the accepting edge
//   op     : 00 LSR, 01 ASR, 10 ROR, 11 behaves as LSR
//   out    : work register, held after completion until the next accept
//   carry  : last bit shifted out of bit 0
//   busy   : high while shifting
//   done   : one-cycle completion pulse
module shift_right_seq
    import shift_right_seq_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] in,
    input  logic [5:0]       amount,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] out,
    output logic             carry,
    output logic             busy,
    output logic             done
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] work_q,  work_d;
    logic [5:0]       count_q, count_d;
    logic             carry_q, carry_d;
    op_e              op_q,    op_d;

    logic [WIDTH-1:0] step_data;
    logic             step_bit;

    shr_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .data_i (work_q),
        .op_i   (op_q),
        .data_o (step_data),
        .bit_o  (step_bit)
    );

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        count_d = count_q;
        carry_d = carry_q;
        op_d    = op_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    work_d  = in;
                    op_d    = op_e'(op);
                    count_d = eff_amount(op_e'(op), amount);
                    carry_d = 1'b0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // The edge that sees count==0 is spent moving to DONE, which
                // gives the N+1 cycle latency with zero-length shifts included.
                if (count_q != 6'd0) begin
                    work_d  = step_data;
                    carry_d = step_bit;
                    count_d = count_q - 6'd1;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            work_q  <= '0;
            count_q <= 6'd0;
            carry_q <= 1'b0;
            op_q    <= OP_LSR;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            count_q <= count_d;
            carry_q <= carry_d;
            op_q    <= op_d;
        end
    end

    assign out   = work_q;
    assign carry = carry_q;
    assign busy  = (state_q == ST_SHIFT);
    assign done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_shift_right_seq.sv
module tb_shift_right_seq;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [W-1:0]  in_v;
    logic [5:0]    amount;
    logic [1:0]    op;
    logic [W-1:0]  out_v;
    logic          carry;
    logic          busy;
    logic          done;

    shift_right_seq #(.WIDTH(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .in     (in_v),
        .amount (amount),
        .op     (op),
        .out    (out_v),
        .carry  (carry),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] out;
        logic         carry;
        int           lat;
        int           acc;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int overlap  = 0;
    int dbl_done = 0;

    logic         prev_done  = 1'b0;
    logic [W-1:0] prev_out   = '0;
    logic         prev_carry = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Closed-form reference for the whole multi-step shift.
    function automatic exp_t model(input logic [W-1:0] d, input logic [5:0] a, input logic [1:0] o);
        exp_t e;
        int   n;
        logic [4:0] a_lo;
        a_lo = a[4:0];
        if (o == 2'b10) n = int'(a_lo);
        else            n = (a > 6'd32) ? 32 : int'(a);
        e.carry = (n == 0) ? 1'b0 : d[n-1];
        case (o)
            2'b01:   e.out = W'($signed(d) >>> n);
            2'b10:   e.out = (n == 0) ? d : ((d >> n) | (d << (W - n)));
            default: e.out = (n >= W) ? '0 : (d >> n);
        endcase
        e.lat = n + 1;
        e.acc = 0;
        return e;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: pops the scoreboard on each done pulse.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (busy && done) overlap++;
        if (prev_done && done) dbl_done++;
        if (prev_done) begin
            check("out_hold", out_v, prev_out);
            check("carry_hold", carry, prev_carry);
        end
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                check("out", out_v, e.out);
                check("carry", carry, e.carry);
                check("latency", cyc - e.acc, e.lat);
            end
        end
        prev_done  = (done === 1'b1);
        prev_out   = out_v;
        prev_carry = carry;
    end

    // Drive one request once the DUT is idle; returns on the negedge after the accepting edge.
    task automatic issue(input logic [W-1:0] d, input logic [5:0] a, input logic [1:0] o);
        exp_t e;
        int   guard = 0;
        @(negedge clk);
        while ((busy || done) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) check("idle_timeout", 1, 0);
        in_v   = d;
        amount = a;
        op     = o;
        start  = 1'b1;
        e      = model(d, a, o);
        e.acc  = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while ((sb.size() != 0 || busy || done) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            check("drain_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    initial begin
        exp_t e;
        int   cnt;
        int   acc1;
        reset  = 1'b1;
        start  = 1'b0;
        in_v   = '0;
        amount = '0;
        op     = 2'b00;
        repeat (3) @(negedge clk);
        check("rst_out", out_v, 0);
        check("rst_carry", carry, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        reset = 1'b0;

        // Directed cases with known results.
        issue(32'h8000_0001, 6'd1,  2'b00); drain();
        issue(32'h8000_0000, 6'd4,  2'b01); drain();
        issue(32'h8000_0000, 6'd40, 2'b01); drain();
        issue(32'h0000_000F, 6'd4,  2'b10); drain();
        issue(32'hDEAD_BEEF, 6'd32, 2'b10); drain();
        issue(32'hFFFF_FFFF, 6'd32, 2'b00); drain();
        issue(32'hFFFF_FFFF, 6'd32, 2'b11); drain();
        issue(32'h1234_5678, 6'd0,  2'b01); drain();
        issue(32'h0F0F_1234, 6'd63, 2'b10); drain();

        // Model spot-checks against hand-derived values.
        e = model(32'h8000_0000, 6'd40, 2'b01);
        check("ref_asr40", {e.carry, e.out}, {1'b1, 32'hFFFF_FFFF});

        // Stray start during an LSR by 8 must be ignored.
        issue(32'hA5A5_A5A5, 6'd8, 2'b00);
        cnt = 0;
        while (busy && cnt < 100) begin
            if (cnt == 2) begin
                in_v  = 32'h1234_5678;
                start = 1'b1;
            end
            if (cnt == 3) start = 1'b0;
            cnt++;
            @(negedge clk);
        end
        start = 1'b0;
        check("busy_len", cnt, 9);
        drain();

        // Reset 3 cycles into an LSR by 10.
        issue(32'hCAFE_F00D, 6'd10, 2'b00);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        void'(sb.pop_back());
        @(negedge clk);
        reset = 1'b0;
        check("abort_out", out_v, 0);
        check("abort_carry", carry, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        repeat (15) @(negedge clk);
        issue(32'hCAFE_F00D, 6'd10, 2'b00); drain();

        // Start held high: second accept lands on the first IDLE edge after DONE.
        @(negedge clk);
        in_v   = 32'h0000_0F00;
        amount = 6'd3;
        op     = 2'b01;
        start  = 1'b1;
        acc1   = cyc + 1;
        e = model(32'h0000_0F00, 6'd3, 2'b01);
        e.acc = acc1;
        sb.push_back(e);
        e.acc = acc1 + e.lat + 2;
        sb.push_back(e);
        cnt = 0;
        while (cyc < e.acc && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        start = 1'b0;
        drain();

        // Random mix.
        for (int i = 0; i < 12; i++) begin
            issue($urandom, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3)));
            drain();
        end

        check("busy_done_excl", overlap, 0);
        check("done_single", dbl_done, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got cycle %0d expected finish", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/shift_right_seq.md
SHIFT_RIGHT_SEQ -- requirements
Module: shift_right_seq

Interface
REQ-001 Parameter: WIDTH, default 32, data width of operand and result.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset; sampled on rising clk edge.
REQ-004 start  input  1  request; accepted only in IDLE.
REQ-005 in  input  WIDTH  operand, captured on the accepting edge.
REQ-006 amount  input  6  shift count 0..63, captured on the accepting edge.
REQ-007 op  input  2  shift type: 00 LSR, 01 ASR, 10 ROR, 11 reserved (executes as LSR).
REQ-008 out  output  WIDTH  result register; valid while done=1, held until the next accepted start.
REQ-009 carry  output  1  last bit shifted out of bit 0; held with out.
REQ-010 busy  output  1  high in SHIFT state.
REQ-011 done  output  1  single-cycle completion pulse.

Function
REQ-012 FSM states shall be IDLE, SHIFT and DONE.
REQ-013 IDLE with start=1 at an edge: load work register=in, load count=effective amount, clear carry, go to SHIFT.
REQ-014 Effective amount: LSR/ASR min(amount,32); ROR amount[4:0].
REQ-015 SHIFT with count>0 at an edge: shift one position right, set carry=old bit 0, decrement count.
REQ-016 Shift fill: LSR inserts 0; ASR replicates old MSB; ROR inserts old bit 0.
REQ-017 SHIFT with count=0 at an edge: go to DONE, drive done=1 for exactly that cycle.
REQ-018 DONE always returns to IDLE on the next edge; done deasserts there.
REQ-019 Latency: done visible N+1 cycles after the accepting edge (N = effective amount); amount 0 gives done 1 cycle after, out=in, carry=0.
REQ-020 start while busy=1 or done=1 is ignored; inputs are not re-captured.
REQ-021 start held high continuously is re-accepted on the first IDLE edge following DONE.
REQ-022 out shall reflect the work register at all times; carry and out are stable from done until the next accepted start.
REQ-023 busy and done shall never be high in the same cycle.

Reset
REQ-024 reset=1 at an edge forces IDLE, out=0, carry=0, count=0, busy=0, done=0, regardless of state.
REQ-025 reset during SHIFT abandons the operation; no done pulse is produced for it.
REQ-026 reset has priority over start in the same cycle.

Structure
REQ-027 A shared package shall hold the op encodings (LSR/ASR/ROR), the FSM state encoding and the default WIDTH.
REQ-028 One combinational sub-module, shr_step, shall compute a one-bit right step (data in, op -> data out, shifted-out bit); the FSM and registers stay in shift_right_seq.

Verification
REQ-029 LSR in=0x80000001 amount=1 -> out=0x40000000, carry=1, done 2 cycles after accepting edge.
REQ-030 ASR in=0x80000000 amount=4 -> out=0xF8000000, carry=0; ASR in=0x80000000 amount=40 -> out=0xFFFFFFFF, carry=1, done 33 cycles after accept.
REQ-031 ROR in=0x0000000F amount=4 -> out=0xF0000000, carry=1; ROR amount=32 -> out=in, carry=0, done 1 cycle after accept.
REQ-032 LSR in=0xFFFFFFFF amount=32 -> out=0x00000000, carry=1; op=11 same stimulus -> identical result.
REQ-033 start pulsed with in=0x12345678 during an in-progress LSR by 8 -> ignored, first result unchanged, busy never drops early.
REQ-034 reset asserted 3 cycles into an LSR by 10 -> next cycle IDLE, out=0, carry=0, no done pulse; a fresh start then completes normally.
